// File: rtl/spi_slave_txrx.sv
// Full-duplex SPI slave, parameterised width/mode, one-word TX holding register.
// Optional underrun pulse on txu: define SPI_SLAVE_TXRX_UNDERRUN_EN.
module spi_slave_txrx #(
    parameter int W    = 8,
    parameter int SYNC = 3,
    parameter int CPOL = 0,
    parameter int CPHA = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cs,
    input  logic         sclk,
    input  logic         mosi,
    output logic         miso,
    output logic         miso_oe,
    input  logic [W-1:0] txd,
    input  logic         txdv,
    output logic         txrdy,
    output logic [W-1:0] rxd,
    output logic         rxdv,
    output logic         rxe,
    output logic         txu
);
    localparam int   CW  = $clog2(W);
    localparam logic POL = 1'(CPOL);

    typedef enum logic [1:0] {ST_WAIT, ST_IDLE, ST_ACTIVE, ST_END} state_t;

    logic [SYNC-1:0] cs_sq, sclk_sq, mosi_sq;
    logic            sclk_dq;
    logic            cs_s, sclk_s, mosi_s;
    logic            lead, trail, sample, shift;

    state_t          state_q, state_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [W-1:0]    rx_sr_q, rx_sr_d;
    logic [W-1:0]    tx_sr_q, tx_sr_d;
    logic [W-1:0]    rxd_q, rxd_d;
    logic [W-1:0]    hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic            rxdv_q, rxdv_d;
    logic            load;

    // cs resets asserted so ST_WAIT only leaves on a genuine deassert
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sq   <= '0;
            sclk_sq <= {SYNC{POL}};
            mosi_sq <= '0;
            sclk_dq <= POL;
        end else begin
            cs_sq   <= {cs_sq[SYNC-2:0], cs};
            sclk_sq <= {sclk_sq[SYNC-2:0], sclk};
            mosi_sq <= {mosi_sq[SYNC-2:0], mosi};
            sclk_dq <= sclk_sq[SYNC-1];
        end
    end

    assign cs_s   = cs_sq[SYNC-1];
    assign sclk_s = sclk_sq[SYNC-1];
    assign mosi_s = mosi_sq[SYNC-1];
    assign lead   = (sclk_dq == POL) && (sclk_s != POL);
    assign trail  = (sclk_dq != POL) && (sclk_s == POL);
    assign sample = (CPHA != 0) ? trail : lead;
    assign shift  = (CPHA != 0) ? lead : trail;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        rxd_d       = rxd_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rxdv_d      = 1'b0;
        load        = 1'b0;
        unique case (state_q)
            ST_WAIT: begin
                if (cs_s) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (!cs_s) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
                    rx_sr_d   = '0;
                    load      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_s) begin
                    state_d   = ST_END;
                    bit_cnt_d = '0;
                    rx_sr_d   = '0;
                    tx_sr_d   = '0;
                end else if (sample) begin
                    rx_sr_d = {rx_sr_q[W-2:0], mosi_s};
                    if (bit_cnt_q == CW'(W-1)) begin
                        rxd_d     = rx_sr_d;
                        rxdv_d    = 1'b1;
                        bit_cnt_d = '0;
                        load      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end else if (shift && bit_cnt_q != '0) begin
                    tx_sr_d = tx_sr_q << 1;
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_WAIT;
        endcase
        if (load) begin
            tx_sr_d     = hold_full_q ? hold_q : '0;
            hold_full_d = 1'b0;
        end
        if (txdv && !hold_full_q) begin
            hold_d      = txd;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_WAIT;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            rxd_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rxdv_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            rxd_q       <= rxd_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rxdv_q      <= rxdv_d;
        end
    end

`ifdef SPI_SLAVE_TXRX_UNDERRUN_EN
    logic txu_q, txu_d;

    always_comb begin
        txu_d = load && !hold_full_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) txu_q <= 1'b0;
        else        txu_q <= txu_d;
    end

    assign txu = txu_q;
`else
    assign txu = 1'b0;
`endif

    assign miso    = tx_sr_q[W-1];
    assign miso_oe = !cs_s && (state_q != ST_WAIT);
    assign txrdy   = !hold_full_q;
    assign rxd     = rxd_q;
    assign rxdv    = rxdv_q;
    assign rxe     = (state_q == ST_END);
endmodule

// File: tb/tb_spi_slave_txrx.sv
// Directed bench: mode-0 W=8 instance and mode-3 W=16 instance of spi_slave_txrx.
module tb_spi_slave_txrx;
`ifdef SPI_SLAVE_TXRX_UNDERRUN_EN
    localparam int UND = 1;
`else
    localparam int UND = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic cs0 = 1'b1, sclk0 = 1'b0, mosi0 = 1'b0, txdv0 = 1'b0;
    logic [7:0] txd0 = '0;
    logic miso0, oe0, txrdy0, rxdv0, rxe0, txu0;
    logic [7:0] rxd0;

    logic cs1 = 1'b1, sclk1 = 1'b1, mosi1 = 1'b0, txdv1 = 1'b0;
    logic [15:0] txd1 = '0;
    logic miso1, oe1, txrdy1, rxdv1, rxe1, txu1;
    logic [15:0] rxd1;

    spi_slave_txrx #(.W(8), .SYNC(3), .CPOL(0), .CPHA(0)) u0 (
        .clk(clk), .rst_n(rst_n), .cs(cs0), .sclk(sclk0), .mosi(mosi0),
        .miso(miso0), .miso_oe(oe0), .txd(txd0), .txdv(txdv0),
        .txrdy(txrdy0), .rxd(rxd0), .rxdv(rxdv0), .rxe(rxe0), .txu(txu0)
    );

    spi_slave_txrx #(.W(16), .SYNC(3), .CPOL(1), .CPHA(1)) u1 (
        .clk(clk), .rst_n(rst_n), .cs(cs1), .sclk(sclk1), .mosi(mosi1),
        .miso(miso1), .miso_oe(oe1), .txd(txd1), .txdv(txdv1),
        .txrdy(txrdy1), .rxd(rxd1), .rxdv(rxdv1), .rxe(rxe1), .txu(txu1)
    );

    int checks = 0;
    int errors = 0;

    int rx0_n = 0, rxe0_n = 0, txu0_n = 0;
    logic [7:0] rx0_last = '0;
    int rx1_n = 0, rxe1_n = 0;
    logic [15:0] rx1_log [4];

    always @(posedge clk) begin
        if (rxdv0) begin
            rx0_n    <= rx0_n + 1;
            rx0_last <= rxd0;
        end
        if (rxe0) rxe0_n <= rxe0_n + 1;
        if (txu0) txu0_n <= txu0_n + 1;
        if (rxdv1) begin
            if (rx1_n < 4) rx1_log[rx1_n] <= rxd1;
            rx1_n <= rx1_n + 1;
        end
        if (rxe1) rxe1_n <= rxe1_n + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic txw0(input logic [7:0] v);
        for (int k = 0; k < 100 && !txrdy0; k++) wclk(1);
        chk("txrdy0_wait", 32'(txrdy0), 32'd1);
        txd0 = v; txdv0 = 1'b1;
        wclk(1);
        txdv0 = 1'b0;
    endtask

    task automatic txw1(input logic [15:0] v);
        for (int k = 0; k < 100 && !txrdy1; k++) wclk(1);
        chk("txrdy1_wait", 32'(txrdy1), 32'd1);
        txd1 = v; txdv1 = 1'b1;
        wclk(1);
        txdv1 = 1'b0;
    endtask

    task automatic bits0(input logic [7:0] mo, input int n,
                         output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < n; i++) begin
            mosi0 = mo[7-i];
            wclk(8);
            mi[7-i] = miso0;
            sclk0 = 1'b1;
            wclk(8);
            sclk0 = 1'b0;
        end
    endtask

    task automatic bits1(input logic [15:0] mo, output logic [15:0] mi);
        mi = '0;
        for (int i = 0; i < 16; i++) begin
            sclk1 = 1'b0;
            mosi1 = mo[15-i];
            wclk(8);
            mi[15-i] = miso1;
            sclk1 = 1'b1;
            wclk(8);
        end
    endtask

    task automatic frame0(input logic [7:0] mo, input int n,
                          output logic [7:0] mi);
        cs0 = 1'b0;
        wclk(10);
        bits0(mo, n, mi);
        wclk(8);
        cs0 = 1'b1;
        wclk(10);
    endtask

    initial begin
        logic [7:0] mi0;
        logic [15:0] m1a, m1b;
        int rn, en, un;

        wclk(3);
        chk("rst_miso", 32'(miso0), 32'd0);
        chk("rst_oe", 32'(oe0), 32'd0);
        chk("rst_txrdy", 32'(txrdy0), 32'd1);
        chk("rst_rxd", 32'(rxd0), 32'd0);
        chk("rst_rxdv", 32'(rxdv0), 32'd0);
        chk("rst_rxe", 32'(rxe0), 32'd0);
        chk("rst_txu", 32'(txu0), 32'd0);
        rst_n = 1'b1;
        wclk(10);

        // 1: preload 0xA5, receive 0x3C
        txw0(8'hA5);
        chk("t1_txrdy_full", 32'(txrdy0), 32'd0);
        rn = rx0_n; en = rxe0_n; un = txu0_n;
        cs0 = 1'b0;
        wclk(10);
        chk("t1_oe", 32'(oe0), 32'd1);
        chk("t1_txrdy_load", 32'(txrdy0), 32'd1);
        bits0(8'h3C, 8, mi0);
        wclk(8);
        cs0 = 1'b1;
        wclk(10);
        chk("t1_rxdv_n", 32'(rx0_n - rn), 32'd1);
        chk("t1_rxd", 32'(rxd0), 32'h3C);
        chk("t1_rx_last", 32'(rx0_last), 32'h3C);
        chk("t1_miso", 32'(mi0), 32'hA5);
        chk("t1_rxe_n", 32'(rxe0_n - en), 32'd1);
        chk("t1_txu_n", 32'(txu0_n - un), 32'(UND));
        chk("t1_oe_off", 32'(oe0), 32'd0);

        // 6: txdv while full is ignored
        txw0(8'h11);
        txd0 = 8'h77; txdv0 = 1'b1;
        wclk(5);
        chk("t6_txrdy_held", 32'(txrdy0), 32'd0);
        txdv0 = 1'b0;
        frame0(8'h00, 8, mi0);
        chk("t6_miso", 32'(mi0), 32'h11);
        chk("t6_rxd", 32'(rxd0), 32'h00);

        // 3: empty holding register -> zeros, underrun at cs assert
        rn = rx0_n; un = txu0_n;
        cs0 = 1'b0;
        wclk(10);
        chk("t3_txu_cs", 32'(txu0_n - un), 32'(UND));
        bits0(8'h96, 8, mi0);
        wclk(8);
        cs0 = 1'b1;
        wclk(10);
        chk("t3_miso", 32'(mi0), 32'h00);
        chk("t3_rxd", 32'(rxd0), 32'h96);
        chk("t3_rxdv_n", 32'(rx0_n - rn), 32'd1);
        chk("t3_txu_n", 32'(txu0_n - un), 32'(2 * UND));

        // 4: aborted 5-bit frame, then good 0x81
        rn = rx0_n; en = rxe0_n;
        frame0(8'hF0, 5, mi0);
        chk("t4_rxdv_n", 32'(rx0_n - rn), 32'd0);
        chk("t4_rxe_n", 32'(rxe0_n - en), 32'd1);
        chk("t4_rxd_kept", 32'(rxd0), 32'h96);
        frame0(8'h81, 8, mi0);
        chk("t4_rxd_next", 32'(rxd0), 32'h81);
        chk("t4_rxdv_next", 32'(rx0_n - rn), 32'd1);

        // 0-bit transfer still signals end
        en = rxe0_n;
        frame0(8'h00, 0, mi0);
        chk("t4_rxe_zero", 32'(rxe0_n - en), 32'd1);

        // 2: mode 3, two 16-bit words in one frame
        txw1(16'hCAFE);
        cs1 = 1'b0;
        wclk(10);
        txw1(16'h0F0F);
        bits1(16'h1234, m1a);
        bits1(16'hBEEF, m1b);
        wclk(8);
        cs1 = 1'b1;
        wclk(10);
        chk("t2_rxdv_n", 32'(rx1_n), 32'd2);
        chk("t2_rx0", 32'(rx1_log[0]), 32'h1234);
        chk("t2_rx1", 32'(rx1_log[1]), 32'hBEEF);
        chk("t2_miso0", 32'(m1a), 32'hCAFE);
        chk("t2_miso1", 32'(m1b), 32'h0F0F);
        chk("t2_rxe_n", 32'(rxe1_n), 32'd1);

        // 5: reset mid-frame, release while cs still low
        cs0 = 1'b0;
        wclk(10);
        bits0(8'hE0, 3, mi0);
        rst_n = 1'b0;
        wclk(3);
        chk("t5_rst_rxd", 32'(rxd0), 32'd0);
        rst_n = 1'b1;
        rn = rx0_n;
        wclk(10);
        chk("t5_oe_wait", 32'(oe0), 32'd0);
        bits0(8'hFF, 8, mi0);
        wclk(8);
        chk("t5_no_rxdv", 32'(rx0_n - rn), 32'd0);
        cs0 = 1'b1;
        wclk(10);
        frame0(8'h55, 8, mi0);
        chk("t5_rxd", 32'(rxd0), 32'h55);
        chk("t5_rxdv_n", 32'(rx0_n - rn), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
